handshake_fifo: RTL and testbench

- Parameterised valid/ready elastic FIFO placed between the handshake master agent interface and the DUT data input.
- Decouples producer stalls from consumer back-pressure.
- Upstream (slave side) accepts beats on s_vld&&s_rdy; downstream (master side) presents beats on m_vld and retires them on m_vld&&m_rdy.
- Strict in-order delivery, no data loss, no duplication.

---
 rtl/handshake_fifo_pkg.sv | 8 +
 rtl/handshake_fifo_mem.sv | 21 ++
 rtl/handshake_fifo.sv | 65 ++++++
 tb/tb_handshake_fifo.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/handshake_fifo_pkg.sv
// handshake_pkg: shared width defaults, data type and level-width helper for handshake_fifo.
package handshake_pkg;
    localparam int DEFAULT_DATA_W = 32;
    typedef logic [DEFAULT_DATA_W-1:0] handshake_data_t;
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/handshake_fifo_mem.sv
// handshake_fifo_mem: DEPTH x DATA_W register array, one write port, one asynchronous read port.
module handshake_fifo_mem
    import handshake_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = 4,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    // Storage is deliberately unreset; it is never observed while empty.
    always_ff @(posedge clk)
        if (we_i) mem_q[waddr_i] <= wdata_i;
    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/handshake_fifo.sv
// handshake_fifo: valid/ready elastic FIFO with registered s_rdy/m_vld and one-cycle latency.
// Define HANDSHAKE_FIFO_WATERMARK_EN to add the sticky max_level output.
module handshake_fifo
    import handshake_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = level_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_vld,
    output logic              s_rdy,
    output logic [DATA_W-1:0] m_data,
    output logic              m_vld,
    input  logic              m_rdy,
    output logic [CNT_W-1:0]  level
`ifdef HANDSHAKE_FIFO_WATERMARK_EN
    ,
    output logic [CNT_W-1:0]  max_level
`endif
);
    localparam int AW = $clog2(DEPTH);
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] level_q, level_d;
    logic             push, pop;
    // Flags come from level_q only, so m_rdy never reaches s_rdy combinationally.
    assign s_rdy = level_q != CNT_W'(DEPTH);
    assign m_vld = level_q != '0;
    assign level = level_q;
    always_comb begin
        push     = s_vld && s_rdy;
        pop      = m_vld && m_rdy;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q + CNT_W'(push) - CNT_W'(pop);
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    handshake_fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (s_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (m_data)
    );
`ifdef HANDSHAKE_FIFO_WATERMARK_EN
    logic [CNT_W-1:0] max_level_q, max_level_d;
    assign max_level_d = level_d > max_level_q ? level_d : max_level_q;
    assign max_level   = max_level_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) max_level_q <= '0;
        else     max_level_q <= max_level_d;
`endif
endmodule

// File: tb/tb_handshake_fifo.sv
// tb_handshake_fifo: directed and scoreboard checks of handshake_fifo (DEPTH=4, DATA_W=32).
module tb_handshake_fifo;
    import handshake_pkg::*;
    logic            clk = 1'b0;
    logic            rst = 1'b1;
    handshake_data_t s_data = '0;
    logic            s_vld = 1'b0;
    logic            s_rdy;
    handshake_data_t m_data;
    logic            m_vld;
    logic            m_rdy = 1'b0;
    logic [2:0]      level;
`ifdef HANDSHAKE_FIFO_WATERMARK_EN
    logic [2:0]      max_level;
`endif
    int total = 0;
    int bad = 0;
    handshake_data_t q[$];
    handshake_data_t prev_data;
    logic was_hold, accepted;
    int sent, got;

    handshake_fifo #(.DATA_W(32), .DEPTH(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .s_data (s_data),
        .s_vld  (s_vld),
        .s_rdy  (s_rdy),
        .m_data (m_data),
        .m_vld  (m_vld),
        .m_rdy  (m_rdy),
        .level  (level)
`ifdef HANDSHAKE_FIFO_WATERMARK_EN
        ,
        .max_level (max_level)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
        total++;
        if (got_v !== exp_v) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got_v, exp_v);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_level", level, 0);
        chk("rst_mvld", m_vld, 0);
        chk("rst_srdy", s_rdy, 1);

        // single beat
        @(negedge clk);
        s_vld = 1'b1; s_data = 32'hA5A5_0001; m_rdy = 1'b1;
        @(negedge clk);
        s_vld = 1'b0;
        chk("one_mvld", m_vld, 1);
        chk("one_data", m_data, 32'hA5A5_0001);
        chk("one_level", level, 1);
        @(negedge clk);
        chk("one_level0", level, 0);
        chk("one_mvld0", m_vld, 0);

        // fill, hold fifth beat, drain
        m_rdy = 1'b0; s_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_data = 32'h10 + i;
            @(negedge clk);
        end
        s_data = 32'h14;
        chk("full_level", level, 4);
        chk("full_srdy", s_rdy, 0);
        chk("full_head", m_data, 32'h10);
        @(negedge clk);
        chk("held_level", level, 4);
        chk("held_srdy", s_rdy, 0);
        m_rdy = 1'b1;
        @(negedge clk);
        chk("pop1_level", level, 3);
        chk("pop1_srdy", s_rdy, 1);
        chk("pop1_data", m_data, 32'h11);
        @(negedge clk);
        s_vld = 1'b0;
        chk("acc14_level", level, 3);
        chk("acc14_data", m_data, 32'h12);
        @(negedge clk);
        chk("d13", m_data, 32'h13);
        @(negedge clk);
        chk("d14", m_data, 32'h14);
        chk("d14_level", level, 1);
        @(negedge clk);
        chk("drain_mvld", m_vld, 0);
        chk("drain_level", level, 0);

        // streaming at level 2
        m_rdy = 1'b0; s_vld = 1'b1;
        s_data = 32'hE0; @(negedge clk);
        s_data = 32'hE1; @(negedge clk);
        m_rdy = 1'b1;
        for (int k = 0; k < 16; k++) begin
            s_data = k;
            chk("str_level", level, 2);
            chk("str_data", m_data, k < 2 ? 32'hE0 + k : k - 2);
            @(negedge clk);
        end
        s_vld = 1'b0;
        chk("str_tail0", m_data, 32'h0E);
        @(negedge clk);
        chk("str_tail1", m_data, 32'h0F);
        @(negedge clk);
        chk("str_empty", m_vld, 0);

        // random producer, toggling consumer
        s_vld = 1'b0; m_rdy = 1'b0; accepted = 1'b1; was_hold = 1'b0;
        sent = 0; got = 0; q.delete();
        for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
            @(negedge clk);
            chk("rnd_level", level, q.size());
            chk("rnd_mvld", m_vld, q.size() != 0);
            if (m_vld && q.size() != 0) chk("rnd_data", m_data, q[0]);
            if (was_hold) chk("rnd_stable", m_data, prev_data);
            if (!s_vld || accepted) begin
                s_vld = (sent < 20) && ($urandom_range(0, 1) == 1);
                if (s_vld) s_data = $urandom;
            end
            m_rdy = !m_rdy;
            accepted = s_vld && s_rdy;
            was_hold = m_vld && !m_rdy;
            prev_data = m_data;
            if (m_vld && m_rdy && q.size() != 0) begin
                void'(q.pop_front());
                got++;
            end
            if (accepted) begin
                q.push_back(s_data);
                sent++;
            end
        end
        chk("rnd_count", got, 20);
        @(negedge clk);
        s_vld = 1'b0; m_rdy = 1'b0;
        repeat (3) @(negedge clk);

        // asynchronous reset mid-transfer
        m_rdy = 1'b1;
        @(negedge clk);
        chk("pre_rst_empty", m_vld, 0);
        m_rdy = 1'b0; s_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_data = 32'h50 + i;
            @(negedge clk);
        end
        s_vld = 1'b0;
        chk("pre_rst_level", level, 3);
        #2 rst = 1'b1;
        #1;
        chk("arst_mvld", m_vld, 0);
        chk("arst_level", level, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_srdy", s_rdy, 1);
        s_vld = 1'b1; s_data = 32'hBEEF; m_rdy = 1'b1;
        @(negedge clk);
        s_vld = 1'b0;
        chk("post_rst_mvld", m_vld, 1);
        chk("post_rst_data", m_data, 32'hBEEF);
        @(negedge clk);
        chk("post_rst_empty", m_vld, 0);

`ifdef HANDSHAKE_FIFO_WATERMARK_EN
        // watermark: reset, fill 3, drain, fill 1
        rst = 1'b1; #1 rst = 1'b0;
        @(negedge clk);
        chk("wm_rst", max_level, 0);
        m_rdy = 1'b0; s_vld = 1'b1;
        repeat (3) @(negedge clk);
        s_vld = 1'b0; m_rdy = 1'b1;
        repeat (3) @(negedge clk);
        m_rdy = 1'b0; s_vld = 1'b1;
        @(negedge clk);
        s_vld = 1'b0;
        chk("wm_level", level, 1);
        chk("wm_max", max_level, 3);
        #2 rst = 1'b1; #1 rst = 1'b0;
        chk("wm_clear", max_level, 0);
        @(negedge clk);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
